playseq_exibidor_sequencia: RTL and testbench

Playback engine for the PlaySeq game. It reads a stored sequence (ROM or the custom RAM) from address 0 up to a programmed last address and drives the LEDs with each entry for a fixed on-time, followed by a dark gap. It is the reader/presenter counterpart of the button-capture and write path in the game datapath, and it sits between the sequence memories and the LED output during the preview phase.

---
 rtl/playseq_pkg.sv | 21 ++
 rtl/playseq_temporizador.sv | 37 +++
 rtl/playseq_exibidor_sequencia.sv | 164 ++++++++++++++++
 tb/tb_playseq_exibidor_sequencia.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/playseq_pkg.sv
// Shared definitions for the PlaySeq sequence playback engine: state codes,
// state width and default phase durations.
package playseq_pkg;

  localparam int ST_W         = 3;
  localparam int T_ON_PADRAO  = 500;
  localparam int T_OFF_PADRAO = 250;

  typedef enum logic [ST_W-1:0] {
    OCIOSO   = 3'd0,
    ENDERECA = 3'd1,
    ACESO    = 3'd2,
    APAGADO  = 3'd3,
    FIM      = 3'd4
  } estado_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/playseq_temporizador.sv
// Phase timer: up-counter cleared by limpa_i, saturating at limite_i.
// fim_o is high while the count equals limite_i (i.e. after limite_i+1 cycles).
module playseq_temporizador
  import playseq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         limpa_i,
  input  logic [W-1:0] limite_i,
  output logic         fim_o
);

  logic [W-1:0] conta_q;
  logic [W-1:0] conta_d;

  always_comb begin
    conta_d = conta_q;
    if (limpa_i) begin
      conta_d = '0;
    end else if (conta_q != limite_i) begin
      conta_d = conta_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conta_q <= '0;
    end else begin
      conta_q <= conta_d;
    end
  end

  assign fim_o = (conta_q == limite_i);

endmodule

// File: rtl/playseq_exibidor_sequencia.sv
// PlaySeq playback engine: walks the sequence memory from 0 to a latched limit,
// lighting each entry for T_ON cycles then a T_OFF dark gap. Optional erro_dado via PLAYSEQ_EXIBIDOR_ERRO_EN.
module playseq_exibidor_sequencia
  import playseq_pkg::*;
#(
  parameter int T_ON   = T_ON_PADRAO,
  parameter int T_OFF  = T_OFF_PADRAO,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] ultimo_end,
  output logic [ADDR_W-1:0] mem_endereco,
  input  logic [DATA_W-1:0] mem_dado,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [ST_W-1:0]   db_estado
`ifdef PLAYSEQ_EXIBIDOR_ERRO_EN
  ,
  output logic              erro_dado
`endif
);

  localparam int TIM_W = $clog2(max_int(T_ON, T_OFF) + 1);

  estado_t           state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] limite_q, limite_d;
  logic [DATA_W-1:0] leds_q, leds_d;
  logic              ocupado_q, pronto_q;
  logic              inicio_aceito;
  logic              entrada_capturada;
  logic              tim_limpa;
  logic              tim_fim;
  logic [TIM_W-1:0]  tim_limite;

  assign tim_limite = (state_q == APAGADO) ? TIM_W'(T_OFF - 1) : TIM_W'(T_ON - 1);

  playseq_temporizador #(
    .W(TIM_W)
  ) u_temporizador (
    .clock    (clock),
    .reset    (reset),
    .limpa_i  (tim_limpa),
    .limite_i (tim_limite),
    .fim_o    (tim_fim)
  );

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    limite_d          = limite_q;
    leds_d            = leds_q;
    tim_limpa         = 1'b1;
    inicio_aceito     = 1'b0;
    entrada_capturada = 1'b0;

    case (state_q)
      OCIOSO: begin
        leds_d = '0;
        addr_d = '0;
        if (iniciar) begin
          limite_d      = ultimo_end;
          inicio_aceito = 1'b1;
          state_d       = ENDERECA;
        end
      end
      ENDERECA: begin
        leds_d            = mem_dado;
        entrada_capturada = 1'b1;
        state_d           = ACESO;
      end
      ACESO: begin
        tim_limpa = tim_fim;
        if (tim_fim) begin
          leds_d  = '0;
          state_d = APAGADO;
        end
      end
      APAGADO: begin
        leds_d    = '0;
        tim_limpa = tim_fim;
        if (tim_fim) begin
          if (addr_q == limite_q) begin
            state_d = FIM;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ENDERECA;
          end
        end
      end
      FIM: begin
        leds_d  = '0;
        state_d = OCIOSO;
      end
      default: begin
        leds_d  = '0;
        addr_d  = '0;
        state_d = OCIOSO;
      end
    endcase

    // Cancel overrides everything, including a simultaneous start request.
    if (abortar) begin
      state_d           = OCIOSO;
      addr_d            = '0;
      limite_d          = limite_q;
      leds_d            = '0;
      tim_limpa         = 1'b1;
      inicio_aceito     = 1'b0;
      entrada_capturada = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= OCIOSO;
      addr_q    <= '0;
      limite_q  <= '0;
      leds_q    <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      limite_q  <= limite_d;
      leds_q    <= leds_d;
      ocupado_q <= (state_d == ENDERECA) || (state_d == ACESO) || (state_d == APAGADO);
      pronto_q  <= (state_d == FIM);
    end
  end

  // The memory registers its address, so present next cycle's address; the
  // entry then arrives during ENDERECA and is captured at its exit edge.
  assign mem_endereco = addr_d;
  assign leds         = leds_q;
  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;
  assign db_estado    = state_q;

`ifdef PLAYSEQ_EXIBIDOR_ERRO_EN
  logic erro_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      erro_q <= 1'b0;
    end else if (inicio_aceito) begin
      erro_q <= 1'b0;
    end else if (entrada_capturada && ($countones(mem_dado) != 1)) begin
      erro_q <= 1'b1;
    end
  end

  assign erro_dado = erro_q;
`else
  logic unused_sinais;
  assign unused_sinais = inicio_aceito ^ entrada_capturada;
`endif

endmodule

// File: tb/tb_playseq_exibidor_sequencia.sv
// Bench for the PlaySeq playback engine with T_ON=4, T_OFF=2 and a registered-read memory model.
module tb_playseq_exibidor_sequencia;

  localparam int T_ON   = 4;
  localparam int T_OFF  = 2;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int P      = 1 + T_ON + T_OFF;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              iniciar = 1'b0;
  logic              abortar = 1'b0;
  logic [ADDR_W-1:0] ultimo_end = '0;
  logic [ADDR_W-1:0] mem_endereco;
  logic [DATA_W-1:0] mem_dado = '0;
  logic [DATA_W-1:0] leds;
  logic              ocupado;
  logic              pronto;
  logic [2:0]        db_estado;
`ifdef PLAYSEQ_EXIBIDOR_ERRO_EN
  logic              erro_dado;
`endif

  logic [DATA_W-1:0] mem [16];
  int vectors = 0;
  int miscompares = 0;

  playseq_exibidor_sequencia #(
    .T_ON   (T_ON),
    .T_OFF  (T_OFF),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .abortar      (abortar),
    .ultimo_end   (ultimo_end),
    .mem_endereco (mem_endereco),
    .mem_dado     (mem_dado),
    .leds         (leds),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .db_estado    (db_estado)
`ifdef PLAYSEQ_EXIBIDOR_ERRO_EN
    ,
    .erro_dado    (erro_dado)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) mem_dado <= mem[mem_endereco];

  task automatic set_pattern();
    for (int i = 0; i < 16; i++) mem[i] = DATA_W'(1 << (i % 4));
  endtask

  // Starts a playback of entries 0..lim and checks every cycle against a schedule
  // derived from the per-entry timing (1 addressing + T_ON lit + T_OFF dark).
  task automatic test_playback(input int lim, input bit noise);
    logic [DATA_W-1:0] snap [16];
    int last, k, r, exp_st, exp_oc, exp_pr;
    logic [DATA_W-1:0] exp_leds;
    int errs_before;
`ifdef PLAYSEQ_EXIBIDOR_ERRO_EN
    logic exp_erro;
`endif
    errs_before = miscompares;
    for (int i = 0; i < 16; i++) snap[i] = mem[i];
    last = (lim + 1) * P;
    ultimo_end = ADDR_W'(lim);
    iniciar = 1'b1;
    for (int j = 0; j <= last + 1; j++) begin
      @(posedge clock);
      #1;
      iniciar = 1'b0;
      k = j / P;
      r = j % P;
      if (j < last) begin
        exp_oc = 1; exp_pr = 0;
        if (r == 0) begin exp_st = 1; exp_leds = '0; end
        else if (r <= T_ON) begin exp_st = 2; exp_leds = snap[k]; end
        else begin exp_st = 3; exp_leds = '0; end
      end else if (j == last) begin
        exp_st = 4; exp_leds = '0; exp_oc = 0; exp_pr = 1;
      end else begin
        exp_st = 0; exp_leds = '0; exp_oc = 0; exp_pr = 0;
      end
      vectors++;
      if (leds !== exp_leds) begin
        miscompares++;
        $display("FAIL play_leds lim=%0d cyc=%0d: got %0d expected %0d", lim, j, leds, exp_leds);
      end
      vectors++;
      if (db_estado !== 3'(exp_st)) begin
        miscompares++;
        $display("FAIL play_state lim=%0d cyc=%0d: got %0d expected %0d", lim, j, db_estado, exp_st);
      end
      vectors++;
      if (ocupado !== 1'(exp_oc)) begin
        miscompares++;
        $display("FAIL play_ocupado lim=%0d cyc=%0d: got %0b expected %0d", lim, j, ocupado, exp_oc);
      end
      vectors++;
      if (pronto !== 1'(exp_pr)) begin
        miscompares++;
        $display("FAIL play_pronto lim=%0d cyc=%0d: got %0b expected %0d", lim, j, pronto, exp_pr);
      end
      if (j < last && r == 0) begin
        vectors++;
        if (mem_endereco !== ADDR_W'(k)) begin
          miscompares++;
          $display("FAIL play_addr lim=%0d cyc=%0d: got %0d expected %0d", lim, j, mem_endereco, k);
        end
      end
`ifdef PLAYSEQ_EXIBIDOR_ERRO_EN
      exp_erro = 1'b0;
      for (int e = 0; e <= lim; e++)
        if ((e * P + 1 <= j) && ($countones(snap[e]) != 1)) exp_erro = 1'b1;
      vectors++;
      if (erro_dado !== exp_erro) begin
        miscompares++;
        $display("FAIL play_erro lim=%0d cyc=%0d: got %0b expected %0b", lim, j, erro_dado, exp_erro);
      end
`endif
      if (noise) begin
        ultimo_end = ADDR_W'($urandom);
        if (j == last) iniciar = 1'b1;
        else if (j < last) iniciar = 1'($urandom);
        else iniciar = 1'b0;
      end
    end
    iniciar = 1'b0;
    $display("playback lim=%0d noise=%0d cycles=%0d new_errors=%0d", lim, noise, last + 2,
             miscompares - errs_before);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    vectors++;
    if ({leds, ocupado, pronto, db_estado, mem_endereco} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: leds=%0d ocupado=%0b pronto=%0b estado=%0d addr=%0d expected all 0",
               leds, ocupado, pronto, db_estado, mem_endereco);
    end
`ifdef PLAYSEQ_EXIBIDOR_ERRO_EN
    vectors++;
    if (erro_dado !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_erro: got %0b expected 0", erro_dado);
    end
`endif
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    $display("reset: initial state checked");
  endtask

  task automatic test_reset_mid_aceso();
    ultimo_end = 4'd3;
    iniciar = 1'b1;
    @(posedge clock); #1; iniciar = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    vectors++;
    if (db_estado !== 3'd2 || leds !== mem[0]) begin
      miscompares++;
      $display("FAIL reset_mid_pre: estado=%0d leds=%0d expected estado 2 leds %0d", db_estado, leds, mem[0]);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (leds !== '0 || ocupado !== 1'b0 || db_estado !== 3'd0 || pronto !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_async: leds=%0d ocupado=%0b estado=%0d pronto=%0b expected 0", leds, ocupado,
               db_estado, pronto);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    $display("reset mid ACESO: asynchronous clear checked");
  endtask

  task automatic test_abort();
    int lim;
    lim = $urandom_range(1, 15);
    ultimo_end = ADDR_W'(lim);
    iniciar = 1'b1;
    for (int j = 0; j <= P + 2; j++) begin
      @(posedge clock); #1;
      iniciar = 1'b0;
    end
    vectors++;
    if (db_estado !== 3'd2 || leds !== mem[1]) begin
      miscompares++;
      $display("FAIL abort_pre: estado=%0d leds=%0d expected estado 2 leds %0d", db_estado, leds, mem[1]);
    end
    abortar = 1'b1;
    iniciar = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (db_estado !== 3'd0 || leds !== '0 || ocupado !== 1'b0 || pronto !== 1'b0 || mem_endereco !== '0) begin
      miscompares++;
      $display("FAIL abort_cancel: estado=%0d leds=%0d ocupado=%0b pronto=%0b addr=%0d expected all 0",
               db_estado, leds, ocupado, pronto, mem_endereco);
    end
    @(posedge clock); #1;
    vectors++;
    if (db_estado !== 3'd0) begin
      miscompares++;
      $display("FAIL abort_priority: estado=%0d expected 0", db_estado);
    end
    abortar = 1'b0;
    iniciar = 1'b0;
    for (int j = 0; j < 2 * P; j++) begin
      @(posedge clock); #1;
      vectors++;
      if (pronto !== 1'b0 || db_estado !== 3'd0) begin
        miscompares++;
        $display("FAIL abort_idle cyc=%0d: pronto=%0b estado=%0d expected 0 0", j, pronto, db_estado);
      end
    end
    $display("abort: lim=%0d cancelled in second ACESO", lim);
    test_playback(lim, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) mem[i] = DATA_W'($urandom_range(0, 15));
      test_playback($urandom_range(0, 5), 1'($urandom));
    end
  endtask

`ifdef PLAYSEQ_EXIBIDOR_ERRO_EN
  task automatic test_erro();
    set_pattern();
    mem[1] = 4'd3;
    test_playback(2, 1'b0);
    set_pattern();
    test_playback(1, 1'b0);
  endtask
`endif

  initial begin
    set_pattern();
    test_reset();
    test_reset_mid_aceso();
    test_playback(2, 1'b0);
    test_playback(0, 1'b0);
    test_playback(15, 1'b0);
    test_playback($urandom_range(1, 6), 1'b1);
    test_abort();
    test_back_to_back();
`ifdef PLAYSEQ_EXIBIDOR_ERRO_EN
    test_erro();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
